// File: rtl/drv8835_stepper_if_if.sv
// Command/drive bundle between motion control and the DRV8835 stepper front end.
// The bench or controller drives the master side; the front end owns the slave side.
interface drv8835_stepper_if_if;
  logic        en;
  logic        dir;
  logic        step;
  logic [15:0] CYCLE_COUNT;
  logic [15:0] DUTY_COUNT;
  logic        drv_a1;
  logic        drv_a2;
  logic        drv_b1;
  logic        drv_b2;

  modport master (
    output en, dir, step, CYCLE_COUNT, DUTY_COUNT,
    input  drv_a1, drv_a2, drv_b1, drv_b2
  );

  modport slave (
    input  en, dir, step, CYCLE_COUNT, DUTY_COUNT,
    output drv_a1, drv_a2, drv_b1, drv_b2
  );
endinterface

// File: rtl/drv8835_stepper_if.sv
// Full-step (two-phase-on) sequencer for a DRV8835 in IN/IN mode, with PWM chopping
// of the coil drive. Outputs coast (all low) whenever disabled or outside the on-window.
module drv8835_stepper_if (
  input  logic                 clk,
  input  logic                 rst,
  drv8835_stepper_if_if.slave  bus
);

  logic [1:0]  phase_reg, phase_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        step_prev_reg;
  // Index 0 is bridge A, index 1 is bridge B.
  logic [1:0]  x1_reg, x1_next;
  logic [1:0]  x2_reg, x2_next;

  logic        step_event;
  logic        cnt_wrap;
  logic        pwm_on;
  logic        drive;
  logic [1:0]  coil_pos;

  assign step_event = bus.en & bus.step & ~step_prev_reg;

  // >= rather than == so shrinking the period mid-count wraps immediately.
  assign cnt_wrap = (bus.CYCLE_COUNT == 16'd0) || (cnt_reg >= (bus.CYCLE_COUNT - 16'd1));
  assign pwm_on   = (cnt_reg < bus.DUTY_COUNT);
  assign drive    = bus.en & pwm_on;

  // A is positive in phases 0 and 3, B is positive in phases 0 and 1.
  assign coil_pos[0] = ~(phase_reg[1] ^ phase_reg[0]);
  assign coil_pos[1] = ~phase_reg[1];

  always_comb begin
    phase_next = phase_reg;
    if (step_event) begin
      if (bus.dir) phase_next = phase_reg - 2'd1;
      else         phase_next = phase_reg + 2'd1;
    end
  end

  always_comb begin
    cnt_next = cnt_reg + 16'd1;
    if (!bus.en || cnt_wrap) cnt_next = 16'd0;
  end

  // Exactly one of x1/x2 is high when driving, so brake is impossible.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bridge
      assign x1_next[gi] = drive &  coil_pos[gi];
      assign x2_next[gi] = drive & ~coil_pos[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg     <= 2'd0;
      cnt_reg       <= 16'd0;
      step_prev_reg <= 1'b0;
      x1_reg        <= 2'b00;
      x2_reg        <= 2'b00;
    end else begin
      phase_reg     <= phase_next;
      cnt_reg       <= cnt_next;
      step_prev_reg <= bus.step;
      x1_reg        <= x1_next;
      x2_reg        <= x2_next;
    end
  end

  assign bus.drv_a1 = x1_reg[0];
  assign bus.drv_a2 = x2_reg[0];
  assign bus.drv_b1 = x1_reg[1];
  assign bus.drv_b2 = x2_reg[1];

endmodule

// File: tb/tb_drv8835_stepper_if.sv
// Scoreboard bench for drv8835_stepper_if: a cycle-level reference model queues the
// expected coil pattern each clock, and a monitor compares it on the falling edge.
module tb_drv8835_stepper_if;

  logic clk = 1'b0;
  logic rst = 1'b1;
  drv8835_stepper_if_if ifc ();

  drv8835_stepper_if dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  // {a1,a2,b1,b2} for phases 0..3: A+B+, A-B+, A-B-, A+B-
  logic [3:0] pattern [4] = '{4'b1010, 4'b0110, 4'b0101, 4'b1001};

  int  m_phase = 0;
  int  m_cnt   = 0;
  bit  m_prev  = 1'b0;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got a1a2b1b2=%b expected %b", name, $time, got, exp);
    end
  endtask

  // Reference model: evaluates the rules with the inputs sampled at each rising edge.
  initial begin
    int cyc;
    int duty;
    logic [3:0] e;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_phase = 0;
        m_cnt   = 0;
        m_prev  = 1'b0;
        exp_q.push_back(4'b0000);
      end else begin
        cyc  = int'(ifc.CYCLE_COUNT);
        duty = int'(ifc.DUTY_COUNT);
        e = (ifc.en && (m_cnt < duty)) ? pattern[m_phase] : 4'b0000;
        exp_q.push_back(e);
        if (ifc.en && ifc.step && !m_prev)
          m_phase = ifc.dir ? (m_phase + 3) % 4 : (m_phase + 1) % 4;
        m_prev = ifc.step;
        if (!ifc.en || cyc == 0 || m_cnt >= cyc - 1) m_cnt = 0;
        else m_cnt = m_cnt + 1;
      end
    end
  end

  // Monitor: every clock the front end presents a new drive pattern.
  initial begin
    logic [3:0] exp;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check("drive", {ifc.drv_a1, ifc.drv_a2, ifc.drv_b1, ifc.drv_b2}, exp);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_step(input logic d, input int gap);
    wait_clk(1);
    ifc.dir  = d;
    ifc.step = 1'b1;
    wait_clk(1);
    ifc.step = 1'b0;
    $display("step dir=%0d duty=%0d cycle=%0d en=%0d", d, ifc.DUTY_COUNT, ifc.CYCLE_COUNT, ifc.en);
    wait_clk(gap);
  endtask

  initial begin
    ifc.en          = 1'b0;
    ifc.dir         = 1'b0;
    ifc.step        = 1'b0;
    ifc.CYCLE_COUNT = 16'd20;
    ifc.DUTY_COUNT  = 16'd10;

    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);
    ifc.en = 1'b1;
    wait_clk(60);

    for (int k = 0; k < 4; k++) do_step(1'b0, 100);
    for (int k = 0; k < 4; k++) do_step(1'b1, 100);

    ifc.DUTY_COUNT = 16'd2;
    for (int k = 0; k < 4; k++) do_step(1'b0, 100);
    for (int k = 0; k < 4; k++) do_step(1'b1, 100);

    ifc.DUTY_COUNT = 16'd2000;
    wait_clk(40);
    for (int k = 0; k < 4; k++) do_step(1'b0, 30);

    // Disable, pulse step while disabled, re-enable.
    ifc.DUTY_COUNT = 16'd10;
    ifc.en = 1'b0;
    wait_clk(5);
    do_step(1'b0, 5);
    ifc.en = 1'b1;
    wait_clk(30);

    // Step held high for 50 clocks must advance once.
    ifc.dir  = 1'b0;
    ifc.step = 1'b1;
    wait_clk(50);
    ifc.step = 1'b0;
    $display("held step released after 50 clocks");
    wait_clk(30);

    // Reach phase 2 with continuous drive, then reset asynchronously mid-PWM.
    do_step(1'b0, 20);
    ifc.DUTY_COUNT = 16'd2000;
    wait_clk(10);
    rst = 1'b1;
    #1;
    check("async_reset", {ifc.drv_a1, ifc.drv_a2, ifc.drv_b1, ifc.drv_b2}, 4'b0000);
    wait_clk(3);
    rst = 1'b0;
    ifc.DUTY_COUNT = 16'd10;
    wait_clk(60);

    // Randomized operation with live period/duty changes.
    for (int k = 0; k < 4000; k++) begin
      ifc.en   = ($urandom_range(0, 19) != 0);
      ifc.dir  = 1'($urandom_range(0, 1));
      ifc.step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        ifc.CYCLE_COUNT = 16'($urandom_range(0, 25));
        ifc.DUTY_COUNT  = 16'($urandom_range(0, 30));
      end
      wait_clk(1);
    end

    ifc.step = 1'b0;
    wait_clk(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout t=%0t got no completion expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
